jg3_code_gen: RTL and testbench

- Sequential inverse of the JG3 3-bit classifier, which maps ABC to X = (ABC >= 4) and Y = (ABC == 0).
- Accepts a requested class {X,Y} and emits a burst of 3-bit ABC codes, each of which classifies to exactly that {X,Y}.
- Walks each class's code set round-robin and keeps its position across requests.
- Acts as the stimulus/transmit end that feeds JG3-style decoders over a valid/ready interface.

---
 rtl/jg3_code_gen_if.sv | 23 ++
 rtl/jg3_code_gen.sv | 136 +++++++++++++
 tb/tb_jg3_code_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/jg3_code_gen_if.sv
// Request/emit bundle between a JG3 code generator and its requester/consumer.
// The slave modport is the generator side; the master modport is the side that
// issues class requests and drains emitted codes.
interface jg3_code_gen_if;
  logic       req_valid;
  logic       X;
  logic       Y;
  logic       req_ready;
  logic [2:0] ABC;
  logic       abc_valid;
  logic       out_ready;
  logic       err;

  modport master (
    output req_valid, X, Y, out_ready,
    input  req_ready, ABC, abc_valid, err
  );

  modport slave (
    input  req_valid, X, Y, out_ready,
    output req_ready, ABC, abc_valid, err
  );
endinterface

// File: rtl/jg3_code_gen.sv
// JG3 code generator: the sequential inverse of the JG3 3-bit classifier
// (X = ABC >= 4, Y = ABC == 0). A request names a class {X,Y}; the block then
// emits BURST codes that all classify back to that class, walking each class's
// code set round-robin with a pointer that survives across requests.
// Optional feature macro: JG3_SELFCHECK_EN adds a chk_fail output driven by an
// internal classifier that re-checks every transferred code.
module jg3_code_gen #(
  parameter int BURST = 1
) (
  input  logic               clk,
  input  logic               rst,
  jg3_code_gen_if.slave      bus
`ifdef JG3_SELFCHECK_EN
  ,
  output logic               chk_fail
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Class encodings as {X,Y}
  localparam logic [1:0] CLS_L = 2'b00;
  localparam logic [1:0] CLS_Z = 2'b01;
  localparam logic [1:0] CLS_H = 2'b10;

  logic [1:0] r_state;
  logic [2:0] r_abc;
  logic       r_valid;
  logic       r_err;
  logic [1:0] r_cls;
  logic [1:0] r_ptrL;
  logic [1:0] r_ptrH;
  logic [3:0] r_remaining;

  logic       w_xfer;
  logic [1:0] w_reqCls;
  logic [1:0] w_nextPtrL;
  logic [1:0] w_nextPtrH;
  logic [2:0] w_acceptCode;
  logic [2:0] w_nextCode;

  // Code selected by a class and the current pointers of the L and H sets.
  // L walks 001..011 (pointer 0..2), H walks 100..111 (pointer 0..3), Z is 000.
  function automatic logic [2:0] codeOf(input logic [1:0] cls,
                                        input logic [1:0] ptrL,
                                        input logic [1:0] ptrH);
    logic [2:0] code;
    case (cls)
      CLS_L:   code = {1'b0, ptrL} + 3'd1;
      CLS_H:   code = {1'b1, ptrH};
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  assign w_reqCls     = {bus.X, bus.Y};
  assign w_xfer       = (r_state == ST_EMIT) && r_valid && bus.out_ready;
  assign w_nextPtrL   = (r_ptrL == 2'd2) ? 2'd0 : r_ptrL + 2'd1;
  assign w_nextPtrH   = r_ptrH + 2'd1;
  assign w_acceptCode = codeOf(w_reqCls, r_ptrL, r_ptrH);
  assign w_nextCode   = codeOf(r_cls, w_nextPtrL, w_nextPtrH);

  assign bus.req_ready = (r_state == ST_IDLE) && !rst;
  assign bus.ABC       = r_abc;
  assign bus.abc_valid = r_valid;
  assign bus.err       = r_err;

  // Main control: accept a class in IDLE, stream the burst in EMIT, pulse err in ERR
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_abc       <= 3'b000;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_cls       <= CLS_L;
      r_ptrL      <= 2'd0;
      r_ptrH      <= 2'd0;
      r_remaining <= 4'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (bus.X && bus.Y) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_cls       <= w_reqCls;
              r_remaining <= 4'(BURST);
              r_abc       <= w_acceptCode;
              r_valid     <= 1'b1;
              r_state     <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (w_xfer) begin
            if (r_cls == CLS_L) r_ptrL <= w_nextPtrL;
            if (r_cls == CLS_H) r_ptrH <= w_nextPtrH;
            r_remaining <= r_remaining - 4'd1;
            if (r_remaining == 4'd1) begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_abc <= w_nextCode;
            end
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef JG3_SELFCHECK_EN
  logic [1:0] w_chkCls;

  assign w_chkCls = {r_abc[2], r_abc == 3'b000};

  // Sticky flag: any transferred code whose classification differs from the latched class
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_fail <= 1'b0;
    end else if (w_xfer && (w_chkCls != r_cls)) begin
      chk_fail <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jg3_code_gen.sv
// Directed testbench for jg3_code_gen. Four instances share clk/rst:
// index 0 BURST=3 (main/round-robin/illegal), 1 BURST=2 (backpressure),
// 2 BURST=4 (reset mid-burst), 3 BURST=15 (self-check build only).
module tb_jg3_code_gen;

  localparam int BURSTS [4] = '{3, 2, 4, 15};

  logic clk = 1'b0;
  logic rst;

  logic [3:0] reqValid;
  logic [3:0] reqX;
  logic [3:0] reqY;
  logic [3:0] outReady;

  logic [2:0] obsAbc [4];
  logic [3:0] obsValid;
  logic [3:0] obsReady;
  logic [3:0] obsErr;
`ifdef JG3_SELFCHECK_EN
  logic [3:0] chkFail;
`endif

  int vecCount  = 0;
  int missCount = 0;

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gInst
    jg3_code_gen_if bus ();

    assign bus.req_valid = reqValid[g];
    assign bus.X         = reqX[g];
    assign bus.Y         = reqY[g];
    assign bus.out_ready = outReady[g];
    assign obsAbc[g]     = bus.ABC;
    assign obsValid[g]   = bus.abc_valid;
    assign obsReady[g]   = bus.req_ready;
    assign obsErr[g]     = bus.err;

    jg3_code_gen #(.BURST(BURSTS[g])) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus)
`ifdef JG3_SELFCHECK_EN
      ,
      .chk_fail (chkFail[g])
`endif
    );
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one clock, then scramble X/Y to show they are not re-sampled
  task automatic applyStimulus(input int which, input logic x, input logic y);
    reqValid[which] = 1'b1;
    reqX[which]     = x;
    reqY[which]     = y;
    tick();
    reqValid[which] = 1'b0;
    reqX[which]     = ~x;
    reqY[which]     = ~y;
  endtask

  // Check n back-to-back codes (out_ready held high), then the return to IDLE
  task automatic expectBurst(input string tag, input int which, input int n, input logic [2:0] codes [4]);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_abc%0d", tag, i), {5'b0, obsAbc[which]}, {5'b0, codes[i]});
      checkOutput($sformatf("%s_valid%0d", tag, i), {7'b0, obsValid[which]}, 8'd1);
      checkOutput($sformatf("%s_ready%0d", tag, i), {7'b0, obsReady[which]}, 8'd0);
      tick();
    end
    checkOutput($sformatf("%s_endvalid", tag), {7'b0, obsValid[which]}, 8'd0);
    checkOutput($sformatf("%s_endready", tag), {7'b0, obsReady[which]}, 8'd1);
    checkOutput($sformatf("%s_endabc", tag), {5'b0, obsAbc[which]}, {5'b0, codes[n-1]});
  endtask

  initial begin
    reqValid = 4'b0000;
    reqX     = 4'b0000;
    reqY     = 4'b0000;
    outReady = 4'b1101;
    rst      = 1'b1;
    tick();
    tick();
    checkOutput("rst_ready", {7'b0, obsReady[0]}, 8'd0);
    checkOutput("rst_valid", {7'b0, obsValid[0]}, 8'd0);
    checkOutput("rst_abc", {5'b0, obsAbc[0]}, 8'd0);
    checkOutput("rst_err", {7'b0, obsErr[0]}, 8'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_ready", {4'b0, obsReady}, 8'hf);

    // High class round-robin across two requests
    applyStimulus(0, 1'b1, 1'b0);
    expectBurst("h1", 0, 3, '{3'b100, 3'b101, 3'b110, 3'b000});
    applyStimulus(0, 1'b1, 1'b0);
    expectBurst("h2", 0, 3, '{3'b111, 3'b100, 3'b101, 3'b000});

    // Low class twice, then zero class, then low again from its own pointer
    applyStimulus(0, 1'b0, 1'b0);
    expectBurst("l1", 0, 3, '{3'b001, 3'b010, 3'b011, 3'b000});
    applyStimulus(0, 1'b0, 1'b0);
    expectBurst("l2", 0, 3, '{3'b001, 3'b010, 3'b011, 3'b000});
    applyStimulus(0, 1'b0, 1'b1);
    expectBurst("z1", 0, 3, '{3'b000, 3'b000, 3'b000, 3'b000});
    applyStimulus(0, 1'b0, 1'b0);
    expectBurst("l3", 0, 3, '{3'b001, 3'b010, 3'b011, 3'b000});

    // Illegal class: single err pulse, no output, pointers untouched
    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("ill_err", {7'b0, obsErr[0]}, 8'd1);
    checkOutput("ill_valid", {7'b0, obsValid[0]}, 8'd0);
    checkOutput("ill_ready", {7'b0, obsReady[0]}, 8'd0);
    tick();
    checkOutput("ill_err_off", {7'b0, obsErr[0]}, 8'd0);
    checkOutput("ill_ready_back", {7'b0, obsReady[0]}, 8'd1);
    checkOutput("ill_valid2", {7'b0, obsValid[0]}, 8'd0);
    applyStimulus(0, 1'b1, 1'b0);
    expectBurst("h3", 0, 3, '{3'b110, 3'b111, 3'b100, 3'b000});
    applyStimulus(0, 1'b0, 1'b0);
    expectBurst("l4", 0, 3, '{3'b001, 3'b010, 3'b011, 3'b000});

    // Backpressure on the BURST=2 instance
    applyStimulus(1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_hold_abc%0d", i), {5'b0, obsAbc[1]}, 8'h04);
      checkOutput($sformatf("bp_hold_valid%0d", i), {7'b0, obsValid[1]}, 8'd1);
      tick();
    end
    outReady[1] = 1'b1;
    checkOutput("bp_rel_abc", {5'b0, obsAbc[1]}, 8'h04);
    tick();
    checkOutput("bp_second_abc", {5'b0, obsAbc[1]}, 8'h05);
    checkOutput("bp_second_valid", {7'b0, obsValid[1]}, 8'd1);
    tick();
    checkOutput("bp_done_valid", {7'b0, obsValid[1]}, 8'd0);
    checkOutput("bp_done_ready", {7'b0, obsReady[1]}, 8'd1);

    // Reset in the middle of a BURST=4 low-class burst
    applyStimulus(2, 1'b0, 1'b0);
    checkOutput("mr_abc0", {5'b0, obsAbc[2]}, 8'h01);
    tick();
    checkOutput("mr_abc1", {5'b0, obsAbc[2]}, 8'h02);
    tick();
    checkOutput("mr_abc2", {5'b0, obsAbc[2]}, 8'h03);
    rst = 1'b1;
    tick();
    checkOutput("mr_valid", {7'b0, obsValid[2]}, 8'd0);
    checkOutput("mr_abc", {5'b0, obsAbc[2]}, 8'h00);
    checkOutput("mr_ready", {7'b0, obsReady[2]}, 8'd0);
    rst = 1'b0;
    tick();
    checkOutput("mr_ready_back", {7'b0, obsReady[2]}, 8'd1);
    applyStimulus(2, 1'b0, 1'b0);
    expectBurst("mr_l", 2, 4, '{3'b001, 3'b010, 3'b011, 3'b001});

`ifdef JG3_SELFCHECK_EN
    // Long bursts of every legal class must never raise chk_fail
    for (int c = 0; c < 3; c++) begin
      int budget;
      applyStimulus(3, c == 2, c == 1);
      budget = 0;
      while (obsValid[3] && budget < 20) begin
        tick();
        budget++;
      end
      checkOutput($sformatf("sc_done%0d", c), {7'b0, obsValid[3]}, 8'd0);
      checkOutput($sformatf("sc_clean%0d", c), {7'b0, chkFail[3]}, 8'd0);
    end
    // Corrupt one transferred high-class code and watch the flag stick
    applyStimulus(3, 1'b1, 1'b0);
    force gInst[3].dut.r_abc = 3'b000;
    tick();
    release gInst[3].dut.r_abc;
    tick();
    checkOutput("sc_flag", {7'b0, chkFail[3]}, 8'd1);
    tick();
    tick();
    checkOutput("sc_sticky", {7'b0, chkFail[3]}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("sc_cleared", {7'b0, chkFail[3]}, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
